column_cursor_ctrl: RTL

- Parametrised successor of the game's button-driven column selector.
- Two raw push-button inputs drive it: move steps a cursor across NUM_COLS columns in either direction, with wrap-around; select issues a drop request for the current column.
- It rotates the turn among NUM_PLAYERS players, rejects drops on full columns, and freezes on game over.
- Sits between the board I/O and the board-state/win-check logic; cursor and player feed the VGA renderer and 7-seg score path.

---
 rtl/column_cursor_pkg.sv | 21 ++
 rtl/btn_edge_sync.sv | 25 ++
 rtl/column_cursor_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/column_cursor_pkg.sv
// rtl/column_cursor_pkg.sv - shared types and wrap helpers for the column cursor controller
package column_cursor_pkg;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   // One wrapping step across n columns: dir=0 moves right, dir=1 moves left.
   function automatic int unsigned next_col(input int unsigned cur, input logic dir,
                                            input int unsigned n);
      int unsigned r;
      if (!dir) r = (cur == n - 1) ? 0 : cur + 1;
      else      r = (cur == 0) ? n - 1 : cur - 1;
      return r;
   endfunction

   function automatic int unsigned next_player(input int unsigned p, input int unsigned n);
      int unsigned r;
      r = (p == n - 1) ? 0 : p + 1;
      return r;
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - two-flop synchroniser plus delay flop giving a one-cycle press pulse
module btn_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   logic sync1_q, sync2_q, dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         dly_q   <= sync2_q;
      end
   end

   assign press_o = sync2_q & ~dly_q;

endmodule

// File: rtl/column_cursor_ctrl.sv
// rtl/column_cursor_ctrl.sv - button-driven column cursor, drop request and turn rotation
// Optional COLUMN_CURSOR_AUTO_SKIP_FULL_EN: move presses skip over full columns.
module column_cursor_ctrl
   import column_cursor_pkg::*;
#(
   parameter  int NUM_COLS    = 16,
   parameter  int NUM_PLAYERS = 2,
   localparam int COL_W       = $clog2(NUM_COLS),
   localparam int PL_W        = $clog2(NUM_PLAYERS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                move_btn,
   input  logic                select_btn,
   input  logic                dir,
   input  logic [NUM_COLS-1:0] col_full,
   input  logic                game_over,
   input  logic                drop_ready,
   output logic [COL_W-1:0]    cursor,
   output logic [PL_W-1:0]     player,
   output logic                drop_valid,
   output logic [COL_W-1:0]    drop_col,
   output logic [PL_W-1:0]     drop_player,
   output logic                reject,
   output logic                frozen
);

   logic move_press, select_press;

   btn_edge_sync u_move_sync (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (move_btn),
      .press_o (move_press)
   );

   btn_edge_sync u_select_sync (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (select_btn),
      .press_o (select_press)
   );

   state_t           state_q, state_d;
   logic [COL_W-1:0] cursor_q, cursor_d, drop_col_q, drop_col_d, move_tgt;
   logic [PL_W-1:0]  player_q, player_d, drop_player_q, drop_player_d;
   logic             reject_q, reject_d;

`ifdef COLUMN_CURSOR_AUTO_SKIP_FULL_EN
   int unsigned cand;
   logic        found;

   // Walk up to NUM_COLS-1 neighbours in dir; the first non-full one wins.
   always_comb begin
      move_tgt = cursor_q;
      cand     = 32'(cursor_q);
      found    = 1'b0;
      for (int k = 1; k < NUM_COLS; k++) begin
         cand = next_col(cand, dir, NUM_COLS);
         if (!found && !col_full[COL_W'(cand)]) begin
            move_tgt = COL_W'(cand);
            found    = 1'b1;
         end
      end
   end
`else
   assign move_tgt = COL_W'(next_col(32'(cursor_q), dir, NUM_COLS));
`endif

   always_comb begin
      state_d       = state_q;
      cursor_d      = cursor_q;
      player_d      = player_q;
      drop_col_d    = drop_col_q;
      drop_player_d = drop_player_q;
      reject_d      = 1'b0;
      if (game_over) begin
         state_d = DONE;
      end else begin
         case (state_q)
            IDLE: begin
               // Select takes precedence; a coincident move is dropped.
               if (select_press) begin
                  if (col_full[cursor_q]) begin
                     reject_d = 1'b1;
                  end else begin
                     state_d       = REQ;
                     drop_col_d    = cursor_q;
                     drop_player_d = player_q;
                  end
               end else if (move_press) begin
                  cursor_d = move_tgt;
               end
            end
            REQ: begin
               if (drop_ready) begin
                  state_d  = IDLE;
                  player_d = PL_W'(next_player(32'(player_q), NUM_PLAYERS));
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cursor_q      <= '0;
         player_q      <= '0;
         drop_col_q    <= '0;
         drop_player_q <= '0;
         reject_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cursor_q      <= cursor_d;
         player_q      <= player_d;
         drop_col_q    <= drop_col_d;
         drop_player_q <= drop_player_d;
         reject_q      <= reject_d;
      end
   end

   assign cursor      = cursor_q;
   assign player      = player_q;
   assign drop_valid  = (state_q == REQ);
   assign drop_col    = drop_col_q;
   assign drop_player = drop_player_q;
   assign reject      = reject_q;
   assign frozen      = (state_q == DONE);

endmodule
